// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: parametrised register file behind the I2C slave byte interface.
//
// Each register is typed by mask: read/write (default), read-only (mirrors ro_in),
// or sticky status (write-1-to-clear, set by sts_set). R/W registers also accept
// fabric writes; an I2C write to the same register in the same cycle wins and the
// dropped fabric write is counted in a saturating collision counter.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   addr, dataIn     I2C register address / write data
//   writeEn          I2C write strobe (one cycle per byte)
//   dataOut          registered I2C read data (1-cycle latency)
//   fab_wr_en/data   per-register fabric write enable / packed data
//   ro_in            packed live values for read-only registers
//   sts_set          packed per-bit set pulses for sticky status registers
//   reg_q            packed combinational view of register contents
//   i2c_wr_pulse     one-cycle pulse per register accepted over I2C
//   irq              registered OR of enabled status bits
//   coll_cnt         saturating count of dropped fabric writes
module i2c_reg_bank #(
  parameter int unsigned                 NUM_REGS    = 8,
  parameter int unsigned                 DATA_W      = 8,
  parameter int unsigned                 ADDR_W      = 8,
  parameter logic [31:0]                 RO_MASK     = 32'h0000_0004,
  parameter logic [31:0]                 W1C_MASK    = 32'h0000_0008,
  parameter int unsigned                 IRQ_EN_ADDR = 4,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL   = '0,
  parameter int unsigned                 CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            dataIn,
  input  logic                         writeEn,
  output logic [DATA_W-1:0]            dataOut,
  input  logic [NUM_REGS-1:0]          fab_wr_en,
  input  logic [NUM_REGS*DATA_W-1:0]   fab_wr_data,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
  input  logic [NUM_REGS*DATA_W-1:0]   sts_set,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          i2c_wr_pulse,
  output logic                         irq,
  output logic [CNT_W-1:0]             coll_cnt
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs_nxt;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_view;
  logic [NUM_REGS-1:0]             w_hit;
  logic [NUM_REGS-1:0]             w_pulse_nxt;
  logic                            w_coll;
  logic [DATA_W-1:0]               w_rd_data;
  logic [DATA_W-1:0]               w_sts_or;
  logic                            w_irq_nxt;
  logic [DATA_W-1:0]               r_data_out;
  logic [NUM_REGS-1:0]             r_wr_pulse;
  logic                            r_irq;
  logic [CNT_W-1:0]                r_coll_cnt;

  // Per-register views: RO registers show the live fabric value, not stored state.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
    assign w_hit[g] = writeEn && (addr == ADDR_W'(g));
    assign w_view[g] = RO_MASK[g] ? ro_in[g*DATA_W +: DATA_W] : r_regs[g];
    assign reg_q[g*DATA_W +: DATA_W] = w_view[g];
  end

  // Next-state per register type. Only one I2C address is active per cycle, so at
  // most one collision can occur regardless of how many fabric enables are high.
  always_comb begin
    w_regs_nxt  = r_regs;
    w_pulse_nxt = '0;
    w_coll      = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RO_MASK[i]) begin
        w_regs_nxt[i] = r_regs[i];
      end else if (W1C_MASK[i]) begin
        // Set is OR-ed in after the clear so it wins a same-cycle conflict.
        w_regs_nxt[i] = (r_regs[i] & ~(w_hit[i] ? dataIn : {DATA_W{1'b0}}))
                        | sts_set[i*DATA_W +: DATA_W];
        w_pulse_nxt[i] = w_hit[i];
      end else if (w_hit[i]) begin
        w_regs_nxt[i]  = dataIn;
        w_pulse_nxt[i] = 1'b1;
        if (fab_wr_en[i]) begin
          w_coll = 1'b1;
        end
      end else if (fab_wr_en[i]) begin
        w_regs_nxt[i] = fab_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read mux; out-of-range addresses fall through to zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        w_rd_data = w_view[i];
      end
    end
  end

  always_comb begin
    w_sts_or = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (W1C_MASK[i]) begin
        w_sts_or = w_sts_or | r_regs[i];
      end
    end
  end

  assign w_irq_nxt = |(w_sts_or & r_regs[IRQ_EN_ADDR]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs     <= RESET_VAL;
      r_data_out <= '0;
      r_wr_pulse <= '0;
      r_irq      <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_regs     <= w_regs_nxt;
      r_data_out <= w_rd_data;
      r_wr_pulse <= w_pulse_nxt;
      r_irq      <= w_irq_nxt;
      if (w_coll && (r_coll_cnt != {CNT_W{1'b1}})) begin
        r_coll_cnt <= r_coll_cnt + CNT_W'(1);
      end
    end
  end

  assign dataOut      = r_data_out;
  assign i2c_wr_pulse = r_wr_pulse;
  assign irq          = r_irq;
  assign coll_cnt     = r_coll_cnt;

  // Slices of the packed inputs that belong to other register types are don't-care.
  logic w_unused;
  assign w_unused = ^{fab_wr_data, ro_in, sts_set, fab_wr_en};

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank with a read-data scoreboard.
module tb_i2c_reg_bank;

  localparam int N = 8;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     addr;
  logic [W-1:0]   dataIn;
  logic           writeEn;
  logic [W-1:0]   dataOut;
  logic [N-1:0]   fab_wr_en;
  logic [N*W-1:0] fab_wr_data;
  logic [N*W-1:0] ro_in;
  logic [N*W-1:0] sts_set;
  logic [N*W-1:0] reg_q;
  logic [N-1:0]   i2c_wr_pulse;
  logic           irq;
  logic [7:0]     coll_cnt;

  i2c_reg_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .dataIn       (dataIn),
    .writeEn      (writeEn),
    .dataOut      (dataOut),
    .fab_wr_en    (fab_wr_en),
    .fab_wr_data  (fab_wr_data),
    .ro_in        (ro_in),
    .sts_set      (sts_set),
    .reg_q        (reg_q),
    .i2c_wr_pulse (i2c_wr_pulse),
    .irq          (irq),
    .coll_cnt     (coll_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rq(input int i);
    return reg_q[i*W +: W];
  endfunction

  // Push the expected read value when the address is driven, pop when dataOut lands.
  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    sb_t e;
    addr = a;
    sb.push_back('{tag: tag, exp: exp});
    tick();
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, {24'd0, dataOut}, {24'd0, e.exp});
    end
  endtask

  task automatic i2c_wr(input logic [7:0] a, input logic [7:0] d);
    addr    = a;
    dataIn  = d;
    writeEn = 1'b1;
    tick();
    writeEn = 1'b0;
  endtask

  logic [7:0] exp_rd [N];

  initial begin
    rst_n       = 1'b0;
    addr        = '0;
    dataIn      = '0;
    writeEn     = 1'b0;
    fab_wr_en   = '0;
    fab_wr_data = '0;
    ro_in       = '0;
    sts_set     = '0;
    repeat (3) tick();
    chk("rst_dataOut", {24'd0, dataOut}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_coll", {24'd0, coll_cnt}, 32'd0);
    chk("rst_regq_lo", reg_q[31:0], 32'd0);
    chk("rst_regq_hi", reg_q[63:32], 32'd0);
    rst_n = 1'b1;
    tick();

    // Fabric writes to every register: RO and W1C must ignore them.
    ro_in[2*W +: W] = 8'h3C;
    fab_wr_en = 8'hFF;
    for (int i = 0; i < N; i++) fab_wr_data[i*W +: W] = 8'(8'h10 + i);
    tick();
    fab_wr_en = '0;
    exp_rd = '{8'h10, 8'h11, 8'h3C, 8'h00, 8'h14, 8'h15, 8'h16, 8'h17};
    for (int i = 0; i < N; i++) rd(8'(i), exp_rd[i], $sformatf("read_%0d", i));
    rd(8'h20, 8'h00, "read_oor_20");
    rd(8'h08, 8'h00, "read_oor_08");

    // R/W write and one-cycle pulse.
    i2c_wr(8'h00, 8'hA5);
    chk("rw_reg0", {24'd0, rq(0)}, 32'hA5);
    chk("rw_pulse_hi", {24'd0, i2c_wr_pulse}, 32'h01);
    tick();
    chk("rw_pulse_lo", {24'd0, i2c_wr_pulse}, 32'h00);

    // RO write ignored.
    i2c_wr(8'h02, 8'hFF);
    chk("ro_no_pulse", {24'd0, i2c_wr_pulse}, 32'h00);
    rd(8'h02, 8'h3C, "ro_read");
    i2c_wr(8'h20, 8'h99);
    chk("oor_no_pulse", {24'd0, i2c_wr_pulse}, 32'h00);

    // Collision on reg1: I2C wins and is counted.
    fab_wr_en = 8'h02;
    fab_wr_data[1*W +: W] = 8'h22;
    i2c_wr(8'h01, 8'h11);
    fab_wr_en = '0;
    chk("coll_reg1", {24'd0, rq(1)}, 32'h11);
    chk("coll_cnt1", {24'd0, coll_cnt}, 32'd1);
    chk("coll_pulse", {24'd0, i2c_wr_pulse}, 32'h02);

    // Fabric write to another register proceeds, no count.
    fab_wr_en = 8'h01;
    fab_wr_data[0*W +: W] = 8'h77;
    i2c_wr(8'h01, 8'h33);
    fab_wr_en = '0;
    chk("nocoll_reg0", {24'd0, rq(0)}, 32'h77);
    chk("nocoll_reg1", {24'd0, rq(1)}, 32'h33);
    chk("nocoll_cnt", {24'd0, coll_cnt}, 32'd1);

    // Mid-run asynchronous reset.
    sts_set[3*W +: W] = 8'h81;
    tick();
    sts_set = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_reg0", {24'd0, rq(0)}, 32'h00);
    chk("mid_rst_reg3", {24'd0, rq(3)}, 32'h00);
    chk("mid_rst_reg4", {24'd0, rq(4)}, 32'h00);
    chk("mid_rst_coll", {24'd0, coll_cnt}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Saturation of the collision counter.
    fab_wr_en = 8'h02;
    addr      = 8'h01;
    dataIn    = 8'h5A;
    writeEn   = 1'b1;
    repeat (254) tick();
    chk("coll_254", {24'd0, coll_cnt}, 32'hFE);
    repeat (46) tick();
    writeEn   = 1'b0;
    fab_wr_en = '0;
    chk("coll_sat", {24'd0, coll_cnt}, 32'hFF);

    // Sticky status register.
    sts_set[3*W +: W] = 8'h05;
    tick();
    sts_set = '0;
    chk("w1c_set", {24'd0, rq(3)}, 32'h05);
    fab_wr_en = 8'h08;
    fab_wr_data[3*W +: W] = 8'hF0;
    i2c_wr(8'h03, 8'h01);
    fab_wr_en = '0;
    chk("w1c_clr", {24'd0, rq(3)}, 32'h04);
    chk("w1c_pulse", {24'd0, i2c_wr_pulse}, 32'h08);
    sts_set[3*W +: W] = 8'h04;
    i2c_wr(8'h03, 8'h04);
    sts_set = '0;
    chk("w1c_set_wins", {24'd0, rq(3)}, 32'h04);
    i2c_wr(8'h03, 8'h04);
    chk("w1c_clr2", {24'd0, rq(3)}, 32'h00);

    // Interrupt with enable on bit 2.
    i2c_wr(8'h04, 8'h04);
    tick();
    chk("irq_idle", {31'd0, irq}, 32'd0);
    sts_set[3*W +: W] = 8'h04;
    tick();
    sts_set = '0;
    chk("irq_n1", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_n2", {31'd0, irq}, 32'd1);
    i2c_wr(8'h03, 8'h04);
    chk("irq_clr_n1", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_clr_n2", {31'd0, irq}, 32'd0);

    // Status bit outside the enable mask does not interrupt.
    sts_set[3*W +: W] = 8'h01;
    tick();
    sts_set = '0;
    repeat (2) tick();
    chk("irq_masked", {31'd0, irq}, 32'd0);

    // Enable cleared: no interrupt at all.
    i2c_wr(8'h04, 8'h00);
    sts_set[3*W +: W] = 8'hFF;
    tick();
    sts_set = '0;
    chk("irq_off_sts", {24'd0, rq(3)}, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("irq_off_%0d", i), {31'd0, irq}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
